// File: rtl/radar_sync_gen.sv
// radar_sync_gen
// Synthetic radar front-end source. It produces the trigger (TRG),
// bearing-increment (BI) and heading-marker (HM) pulses, and a video stream.
// The video is LFSR noise with one injectable point target added on top.
// It stands in for the real front-end so the synchronisation/CFAR chain can
// be exercised on the bench or in an on-board loopback.
//
// Ports:
//   clk          sample clock; all logic updates on the rising edge
//   rst          synchronous, active-low reset
//   enable       run (1) / hold (0)
//   target_range first range cell of the target (sampled at range cell 0)
//   target_bi    bearing index of the target    (sampled at range cell 0)
//   target_amp   amplitude added to the noise   (sampled at range cell 0)
//   TRG          trigger pulse, TRG_WIDTH clocks at the start of every PRI
//   BI           bearing-increment pulse, first PRI of every bearing
//   HM           heading-marker pulse, first PRI of bearing 0
//   video        noise plus target, saturated to DATA_WIDTH bits
//   bi_idx       registered bearing index (debug)
module radar_sync_gen #(
  parameter int                    PRI_CYCLES = 2000,
  parameter int                    RANGE_W    = 11,
  parameter int                    TRG_WIDTH  = 8,
  parameter int                    TRG_PER_BI = 4,
  parameter int                    BI_PER_REV = 4096,
  parameter int                    BI_W       = 12,
  parameter int                    BI_WIDTH   = 8,
  parameter int                    HM_WIDTH   = 8,
  parameter int                    DATA_WIDTH = 14,
  parameter int                    TGT_LEN    = 4,
  parameter logic [DATA_WIDTH-1:0] NOISE_MASK = 14'h00FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [RANGE_W-1:0]    target_range,
  input  logic [BI_W-1:0]       target_bi,
  input  logic [DATA_WIDTH-1:0] target_amp,
  output logic                  TRG,
  output logic                  BI,
  output logic                  HM,
  output logic [DATA_WIDTH-1:0] video,
  output logic [BI_W-1:0]       bi_idx
);

  localparam int TRG_CW = (TRG_PER_BI > 1) ? $clog2(TRG_PER_BI) : 1;

  localparam logic [RANGE_W-1:0] RNG_LAST = RANGE_W'(PRI_CYCLES - 1);
  localparam logic [TRG_CW-1:0]  TRG_LAST = TRG_CW'(TRG_PER_BI - 1);
  localparam logic [BI_W-1:0]    BI_LAST  = BI_W'(BI_PER_REV - 1);

  // Pulse lengths may equal PRI_CYCLES, which need not fit in RANGE_W bits,
  // so all range comparisons are done one bit wider.
  localparam logic [RANGE_W:0] TRG_LIM = (RANGE_W+1)'(TRG_WIDTH);
  localparam logic [RANGE_W:0] BI_LIM  = (RANGE_W+1)'(BI_WIDTH);
  localparam logic [RANGE_W:0] HM_LIM  = (RANGE_W+1)'(HM_WIDTH);
  localparam logic [RANGE_W:0] TGT_EXT = (RANGE_W+1)'(TGT_LEN);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Parameter legality, reported at elaboration.
  if (TRG_WIDTH < 1 || TRG_WIDTH > PRI_CYCLES) begin : g_bad_trg_width
    $error("radar_sync_gen: TRG_WIDTH out of range");
  end
  if (BI_WIDTH < 1 || BI_WIDTH > PRI_CYCLES) begin : g_bad_bi_width
    $error("radar_sync_gen: BI_WIDTH out of range");
  end
  if (HM_WIDTH < 1 || HM_WIDTH > PRI_CYCLES) begin : g_bad_hm_width
    $error("radar_sync_gen: HM_WIDTH out of range");
  end
  if (TGT_LEN < 1 || TGT_LEN > PRI_CYCLES) begin : g_bad_tgt_len
    $error("radar_sync_gen: TGT_LEN out of range");
  end
  if ((1 << RANGE_W) < PRI_CYCLES) begin : g_bad_range_w
    $error("radar_sync_gen: RANGE_W too narrow for PRI_CYCLES");
  end

  logic [RANGE_W-1:0]    rng_cnt;
  logic [TRG_CW-1:0]     trg_cnt;
  logic [BI_W-1:0]       bi_cnt;
  logic [15:0]           lfsr;
  logic [RANGE_W-1:0]    shadow_range;
  logic [BI_W-1:0]       shadow_bi;
  logic [DATA_WIDTH-1:0] shadow_amp;

  logic                  rng_wrap;
  logic                  trg_wrap;
  logic [RANGE_W:0]      rng_ext;
  logic [RANGE_W:0]      hit_lo;
  logic [RANGE_W:0]      hit_hi;
  logic                  hit;
  logic                  lfsr_fb;
  logic [DATA_WIDTH-1:0] noise;
  logic [DATA_WIDTH:0]   video_sum;
  logic                  trg_next;
  logic                  bi_next;
  logic                  hm_next;
  logic [DATA_WIDTH-1:0] video_next;

  // Everything the outputs need is derived from the pre-edge counter state.
  // The target window is compared one bit wide so a target near the end of
  // the sweep is truncated rather than wrapping into the next PRI.
  always_comb begin
    rng_wrap   = (rng_cnt == RNG_LAST);
    trg_wrap   = (trg_cnt == TRG_LAST);
    rng_ext    = {1'b0, rng_cnt};
    hit_lo     = {1'b0, shadow_range};
    hit_hi     = hit_lo + TGT_EXT;
    hit        = (bi_cnt == shadow_bi) && (rng_ext >= hit_lo) && (rng_ext < hit_hi);
    lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    noise      = lfsr[DATA_WIDTH-1:0] & NOISE_MASK;
    video_sum  = {1'b0, noise} + {1'b0, (hit ? shadow_amp : '0)};
    video_next = video_sum[DATA_WIDTH] ? '1 : video_sum[DATA_WIDTH-1:0];
    trg_next   = (rng_ext < TRG_LIM);
    bi_next    = (trg_cnt == '0) && (rng_ext < BI_LIM);
    hm_next    = (bi_cnt == '0) && (trg_cnt == '0) && (rng_ext < HM_LIM);
  end

  // Timing counters, noise LFSR and target shadows advance only on enabled
  // edges. The target is latched at range cell 0, so a mid-sweep change waits
  // for the next PRI instead of tearing the current one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rng_cnt      <= '0;
      trg_cnt      <= '0;
      bi_cnt       <= '0;
      lfsr         <= LFSR_SEED;
      shadow_range <= '0;
      shadow_bi    <= '0;
      shadow_amp   <= '0;
    end else if (enable) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
      if (rng_cnt == '0) begin
        shadow_range <= target_range;
        shadow_bi    <= target_bi;
        shadow_amp   <= target_amp;
      end
      if (rng_wrap) begin
        rng_cnt <= '0;
        if (trg_wrap) begin
          trg_cnt <= '0;
          bi_cnt  <= (bi_cnt == BI_LAST) ? '0 : bi_cnt + 1'b1;
        end else begin
          trg_cnt <= trg_cnt + 1'b1;
        end
      end else begin
        rng_cnt <= rng_cnt + 1'b1;
      end
    end
  end

  // Output registers: pulses and video are blanked while held; the bearing
  // index simply tracks the counter one clock late.
  always_ff @(posedge clk) begin
    if (!rst) begin
      TRG    <= 1'b0;
      BI     <= 1'b0;
      HM     <= 1'b0;
      video  <= '0;
      bi_idx <= '0;
    end else begin
      bi_idx <= bi_cnt;
      if (enable) begin
        TRG   <= trg_next;
        BI    <= bi_next;
        HM    <= hm_next;
        video <= video_next;
      end else begin
        TRG   <= 1'b0;
        BI    <= 1'b0;
        HM    <= 1'b0;
        video <= '0;
      end
    end
  end

endmodule

// File: tb/tb_radar_sync_gen.sv
// tb_radar_sync_gen
// Self-checking bench for radar_sync_gen using a short PRI and a small
// revolution. Expected outputs come from a model that derives the range,
// trigger and bearing positions arithmetically from a count of enabled edges.
module tb_radar_sync_gen;

  localparam int PRI  = 20;
  localparam int TPB  = 2;
  localparam int BPR  = 4;
  localparam int RW   = 5;
  localparam int BW   = 2;
  localparam int TW   = 5;
  localparam int BIW  = 4;
  localparam int HMW  = 3;
  localparam int DW   = 14;
  localparam int TL   = 4;
  localparam int MASK = 'h00FF;
  localparam int VMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [RW-1:0] target_range;
  logic [BW-1:0] target_bi;
  logic [DW-1:0] target_amp;
  logic          TRG;
  logic          BI;
  logic          HM;
  logic [DW-1:0] video;
  logic [BW-1:0] bi_idx;

  int vectors     = 0;
  int miscompares = 0;

  int cur_range = 0;
  int cur_bi    = 0;
  int cur_amp   = 0;

  int          n;
  logic [15:0] m_lfsr;
  int          sh_range;
  int          sh_bi;
  int          sh_amp;

  logic e_trg;
  logic e_bi;
  logic e_hm;
  int   e_video;
  int   e_bidx;

  always #5 clk = ~clk;

  radar_sync_gen #(
    .PRI_CYCLES (PRI),
    .RANGE_W    (RW),
    .TRG_WIDTH  (TW),
    .TRG_PER_BI (TPB),
    .BI_PER_REV (BPR),
    .BI_W       (BW),
    .BI_WIDTH   (BIW),
    .HM_WIDTH   (HMW),
    .DATA_WIDTH (DW),
    .TGT_LEN    (TL),
    .NOISE_MASK (14'h00FF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .target_range (target_range),
    .target_bi    (target_bi),
    .target_amp   (target_amp),
    .TRG          (TRG),
    .BI           (BI),
    .HM           (HM),
    .video        (video),
    .bi_idx       (bi_idx)
  );

  function automatic int mRng();
    return n % PRI;
  endfunction

  function automatic int mPri();
    return (n / PRI) % (TPB * BPR);
  endfunction

  function automatic int mBearing();
    return (n / (PRI * TPB)) % BPR;
  endfunction

  // x^16+x^14+x^13+x^11 Fibonacci LFSR, shifting toward bit 0.
  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    int v;
    int b;
    v = int'(l);
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  // Reference model: expected registered outputs for the edge about to come.
  task automatic modelStep(input logic r, input logic e);
    int  rng;
    int  tc;
    int  bear;
    int  v;
    bit  hit;
    if (!r) begin
      e_trg = 0; e_bi = 0; e_hm = 0; e_video = 0; e_bidx = 0;
      n = 0; m_lfsr = 16'hACE1; sh_range = 0; sh_bi = 0; sh_amp = 0;
    end else begin
      rng    = n % PRI;
      tc     = (n / PRI) % TPB;
      bear   = mBearing();
      e_bidx = bear;
      if (e) begin
        e_trg = (rng < TW);
        e_bi  = (tc == 0) && (rng < BIW);
        e_hm  = (bear == 0) && (tc == 0) && (rng < HMW);
        hit   = (bear == sh_bi) && (rng >= sh_range) && (rng < sh_range + TL);
        v     = (int'(m_lfsr) & MASK) + (hit ? sh_amp : 0);
        e_video = (v > VMAX) ? VMAX : v;
        if (rng == 0) begin
          sh_range = cur_range; sh_bi = cur_bi; sh_amp = cur_amp;
        end
        n      = n + 1;
        m_lfsr = lfsrNext(m_lfsr);
      end else begin
        e_trg = 0; e_bi = 0; e_hm = 0; e_video = 0;
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s at n=%0d: observed=%0d expected=%0d", tag, n, obs, expv);
    end
  endtask

  task automatic checkOutput();
    checkOne("TRG", 32'(TRG), 32'(e_trg));
    checkOne("BI", 32'(BI), 32'(e_bi));
    checkOne("HM", 32'(HM), 32'(e_hm));
    checkOne("video", 32'(video), e_video);
    checkOne("bi_idx", 32'(bi_idx), e_bidx);
  endtask

  task automatic applyStimulus(input logic r, input logic e);
    @(negedge clk);
    rst          = r;
    enable       = e;
    target_range = RW'(cur_range);
    target_bi    = BW'(cur_bi);
    target_amp   = DW'(cur_amp);
    modelStep(r, e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkReached(input string tag, input bit found);
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=not reached expected=reached", tag);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b0; enable = 1'b0;
    target_range = '0; target_bi = '0; target_amp = '0;
    n = 0; m_lfsr = 16'hACE1; sh_range = 0; sh_bi = 0; sh_amp = 0;

    // Reset state
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Pulse timing plus target at range 5, bearing 1, over two revolutions
    cur_range = 5; cur_bi = 1; cur_amp = 100;
    repeat (2 * PRI * TPB * BPR) applyStimulus(1'b1, 1'b1);

    // Saturating amplitude with a target truncated at the end of the sweep
    cur_range = 18; cur_bi = 2; cur_amp = VMAX;
    repeat (PRI * TPB * BPR) applyStimulus(1'b1, 1'b1);

    // Mid-PRI target move: latch range 5 at bearing 3, move to 10 at cell 7
    cur_range = 5; cur_bi = 3; cur_amp = 500;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (mPri() == 6 && mRng() == 7) begin found = 1; break; end
      applyStimulus(1'b1, 1'b1);
    end
    checkReached("wait_mid_pri", found);
    cur_range = 10;
    repeat (2 * PRI + 5) applyStimulus(1'b1, 1'b1);

    // Enable hold for 7 clocks in the middle of a TRG pulse
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (mRng() == 2) begin found = 1; break; end
      applyStimulus(1'b1, 1'b1);
    end
    checkReached("wait_trg_pulse", found);
    repeat (7) applyStimulus(1'b1, 1'b0);
    repeat (3 * PRI) applyStimulus(1'b1, 1'b1);

    // Randomised targets and enable drops
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cur_range = $urandom_range(0, 31);
        cur_bi    = $urandom_range(0, BPR - 1);
        cur_amp   = ($urandom_range(0, 3) == 0) ? VMAX - $urandom_range(0, 300)
                                                : $urandom_range(0, 2000);
      end
      applyStimulus(1'b1, ($urandom_range(0, 7) != 0));
    end

    // Reset mid-pulse at bearing 2
    cur_range = 3; cur_bi = 0; cur_amp = 1000;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (mBearing() == 2 && mRng() == 1) begin found = 1; break; end
      applyStimulus(1'b1, 1'b1);
    end
    checkReached("wait_bearing2", found);
    applyStimulus(1'b0, 1'b1);
    repeat (PRI * TPB + 10) applyStimulus(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
